// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer register map, CTRL layout and FSM.
// The optional prescaler (CTRL[15:8]) is built only when BUS_TIMER_PRESCALE_EN is defined.
package bus_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_PSC_LSB  = 8;
  localparam int CTRL_PSC_MSB  = 15;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Byte-lane merge: lanes with be[i]=1 take the new write data.
  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
      else       res[8*i +: 8] = cur[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Tick generator for the counting phase: one tick every psc+1 cycles.
// Instantiated by bus_timer only when BUS_TIMER_PRESCALE_EN is defined.
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       run,
  input  logic [7:0] psc,
  output logic       tick
);

  logic [7:0] pcnt_r;

  assign tick = (pcnt_r == psc);

  // Divider counter: restarts on timer load, advances only while counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_r <= 8'd0;
    end else if (clr) begin
      pcnt_r <= 8'd0;
    end else if (run) begin
      pcnt_r <= tick ? 8'd0 : pcnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a level irq.
// Define BUS_TIMER_PRESCALE_EN to add the CTRL[15:8] PSC prescaler field.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

`ifdef BUS_TIMER_PRESCALE_EN
  localparam logic [15:0] CTRL_WMASK = 16'hFF0F;
`else
  localparam logic [15:0] CTRL_WMASK = 16'h000F;
`endif

  state_t           state_r;
  logic [15:0]      ctrl_r;
  logic [CNT_W-1:0] preset_r;
  logic [CNT_W-1:0] count_r;
  logic             irq_pend_r;

  logic [31:0] preset_ext_s;
  logic [31:0] count_ext_s;
  logic [31:0] preset_merge_s;
  logic [15:0] ctrl_wr_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        en_next_s;
  logic        force_load_s;
  logic        oneshot_s;
  logic        tick_s;

  // Zero-extend the CNT_W-wide registers onto the 32-bit bus.
  always_comb begin
    preset_ext_s = 32'd0;
    count_ext_s  = 32'd0;
    preset_ext_s[CNT_W-1:0] = preset_r;
    count_ext_s[CNT_W-1:0]  = count_r;
  end

  assign wr_ctrl_s      = we && (addr == ADDR_CTRL);
  assign wr_preset_s    = we && (addr == ADDR_PRESET);
  assign preset_merge_s = be_merge(preset_ext_s, wdata, be);
  assign ctrl_wr_s      = {be[1] ? wdata[15:8] : ctrl_r[15:8],
                           be[0] ? wdata[7:0]  : ctrl_r[7:0]} & CTRL_WMASK;

  // CNT looks at the EN value landing on this edge so a CPU disable beats expiry.
  assign en_next_s    = wr_ctrl_s ? ctrl_wr_s[CTRL_EN] : ctrl_r[CTRL_EN];
  assign force_load_s = wr_preset_s && ctrl_r[CTRL_EN];
  assign oneshot_s    = (ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD) ? 1'b0 : 1'b1;

`ifdef BUS_TIMER_PRESCALE_EN
  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r == ST_LOAD),
    .run   (state_r == ST_CNT),
    .psc   (ctrl_r[CTRL_PSC_MSB:CTRL_PSC_LSB]),
    .tick  (tick_s)
  );
`else
  assign tick_s = 1'b1;
`endif

  // Register file and timer FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ctrl_r     <= 16'd0;
      preset_r   <= {CNT_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      irq_pend_r <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_r <= ctrl_wr_s;
      end else if ((state_r == ST_INT) && oneshot_s && !force_load_s) begin
        ctrl_r[CTRL_EN] <= 1'b0;
      end
      if (wr_preset_s) begin
        preset_r <= preset_merge_s[CNT_W-1:0];
      end
      if (force_load_s) begin
        state_r <= ST_LOAD;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ctrl_r[CTRL_EN] ? ST_LOAD : ST_IDLE;
          ST_LOAD: begin
            count_r    <= preset_r;
            irq_pend_r <= 1'b0;
            state_r    <= ST_CNT;
          end
          ST_CNT: begin
            if (!en_next_s) begin
              state_r <= ST_IDLE;
            end else if (tick_s) begin
              if (count_r > CNT_W'(1)) begin
                count_r <= count_r - CNT_W'(1);
              end else begin
                count_r    <= {CNT_W{1'b0}};
                irq_pend_r <= 1'b1;
                state_r    <= ST_INT;
              end
            end
          end
          ST_INT:  state_r <= oneshot_s ? ST_IDLE : ST_LOAD;
          default: state_r <= ST_IDLE;
        endcase
      end
      if (wr_ctrl_s) begin
        irq_pend_r <= 1'b0;
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    case (addr)
      ADDR_CTRL:   rdata = {16'd0, ctrl_r};
      ADDR_PRESET: rdata = preset_ext_s;
      ADDR_COUNT:  rdata = count_ext_s;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = irq_pend_r & ctrl_r[CTRL_IM];

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed corner cases plus randomized
// one-shot / auto-reload runs checked against a closed-form timing model.
module tb_bus_timer;
  import bus_timer_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [3:0]  be    = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  bus_timer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr  = a;
    wdata = d;
    be    = b;
    we    = 1'b1;
    step();
    we    = 1'b0;
    be    = 4'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input int exp);
    chk(tag, {31'd0, irq}, 32'(exp));
  endtask

  // Reset mid-run, then enable with preset p and compare every cycle to the model.
  task automatic scenario(input int p, input int mode, input int im, input int ncyc);
    int pe, per, j, m, ec, ei, en;
    reset = 1'b0;
    #1;
    chk_rd("rst_count", ADDR_COUNT, 32'd0);
    chk_irq("rst_irq", 0);
    step();
    reset = 1'b1;
    wr(ADDR_PRESET, 32'(p), 4'hF);
    wr(ADDR_CTRL, 32'(im * 8 + mode * 2 + 1), 4'hF);
    pe  = (p == 0) ? 1 : p;
    per = pe + 2;
    for (int k = 1; k <= ncyc; k++) begin
      step();
      if (k == 1) begin
        ec = 0; ei = 0; en = 1;
      end else begin
        j = k - 2;
        if (mode == 1) begin
          m  = j % per;
          ec = (m < pe) ? p - m : 0;
          ei = (im == 1 && j >= pe && m >= pe) ? 1 : 0;
          en = 1;
        end else begin
          ec = (j < pe) ? p - j : 0;
          ei = (j >= pe) ? im : 0;
          en = (j <= pe) ? 1 : 0;
        end
      end
      chk_rd("model_count", ADDR_COUNT, 32'(ec));
      chk_irq("model_irq", ei);
      chk_rd("model_ctrl", ADDR_CTRL, 32'(im * 8 + mode * 2 + en));
    end
    wr(ADDR_CTRL, 32'd0, 4'hF);
    chk_irq("ctrl_write_clears_irq", 0);
  endtask

  initial begin
    int rp;
    // Reset held, then released.
    repeat (2) step();
    for (int a = 0; a < 4; a++) chk_rd("in_reset_rdata", 2'(a), 32'd0);
    chk_irq("in_reset_irq", 0);
    reset = 1'b1;
    step();
    for (int a = 0; a < 4; a++) chk_rd("post_reset_rdata", 2'(a), 32'd0);
    chk_irq("post_reset_irq", 0);

    scenario(5, 0, 1, 10);
    scenario(3, 1, 1, 22);

    // Byte enables, read-only and reserved locations.
    reset = 1'b0; step(); reset = 1'b1;
    wr(ADDR_PRESET, 32'hAABBCCDD, 4'b0101);
    chk_rd("be_preset", ADDR_PRESET, 32'h00BB00DD);
    wr(ADDR_PRESET, 32'h11223344, 4'b0000);
    chk_rd("be_zero_preset", ADDR_PRESET, 32'h00BB00DD);
    wr(ADDR_COUNT, 32'hFFFFFFFF, 4'hF);
    chk_rd("count_readonly", ADDR_COUNT, 32'd0);
    wr(2'd3, 32'hFFFFFFFF, 4'hF);
    chk_rd("reserved_zero", 2'd3, 32'd0);
    wr(ADDR_CTRL, 32'hFFFFFFF6, 4'hF);
`ifdef BUS_TIMER_PRESCALE_EN
    chk_rd("ctrl_wmask", ADDR_CTRL, 32'h0000FF06);
`else
    chk_rd("ctrl_wmask", ADDR_CTRL, 32'h00000006);
`endif
    wr(ADDR_CTRL, 32'd0, 4'hF);

    // Reset asserted with COUNT=3.
    wr(ADDR_PRESET, 32'd5, 4'hF);
    wr(ADDR_CTRL, 32'h9, 4'hF);
    repeat (4) step();
    chk_rd("midcount_before", ADDR_COUNT, 32'd3);
    reset = 1'b0;
    #1;
    chk_rd("midcount_reset_count", ADDR_COUNT, 32'd0);
    chk_irq("midcount_reset_irq", 0);
    step(); reset = 1'b1; repeat (3) step();
    chk_rd("midcount_stays_idle", ADDR_COUNT, 32'd0);

    // Masked expiry: no irq, EN still cleared by hardware.
    wr(ADDR_PRESET, 32'd2, 4'hF);
    wr(ADDR_CTRL, 32'h1, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_irq("masked_irq", 0);
    end
    chk_rd("masked_ctrl", ADDR_CTRL, 32'd0);

    // CPU disables EN on the edge COUNT would go 1 -> 0.
    wr(ADDR_PRESET, 32'd2, 4'hF);
    wr(ADDR_CTRL, 32'h9, 4'hF);
    repeat (3) step();
    chk_rd("race_before", ADDR_COUNT, 32'd1);
    wr(ADDR_CTRL, 32'h8, 4'hF);
    chk_irq("race_irq", 0);
    chk_rd("race_count_held", ADDR_COUNT, 32'd1);
    repeat (3) step();
    chk_rd("race_idle_count", ADDR_COUNT, 32'd1);
    chk_irq("race_idle_irq", 0);

    // CPU CTRL write beats the hardware EN clear in INT.
    wr(ADDR_PRESET, 32'd1, 4'hF);
    wr(ADDR_CTRL, 32'h9, 4'hF);
    repeat (3) step();
    chk_irq("int_irq_set", 1);
    wr(ADDR_CTRL, 32'h9, 4'hF);
    chk_irq("int_write_irq", 0);
    chk_rd("int_write_ctrl", ADDR_CTRL, 32'h9);
    repeat (3) step();
    chk_irq("int_restart_irq", 1);
    wr(ADDR_CTRL, 32'd0, 4'hF);

    // PRESET write while enabled restarts the count.
    wr(ADDR_PRESET, 32'd5, 4'hF);
    wr(ADDR_CTRL, 32'h9, 4'hF);
    repeat (3) step();
    chk_rd("restart_before", ADDR_COUNT, 32'd4);
    wr(ADDR_PRESET, 32'd9, 4'hF);
    chk_rd("restart_load_cycle", ADDR_COUNT, 32'd4);
    step();
    chk_rd("restart_loaded", ADDR_COUNT, 32'd9);
    step();
    chk_rd("restart_dec", ADDR_COUNT, 32'd8);
    wr(ADDR_CTRL, 32'd0, 4'hF);

    // Randomized runs.
    for (int n = 0; n < 12; n++) begin
      rp = int'($urandom_range(0, 9));
      scenario(rp, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 3 * (rp + 2) + 4);
    end

`ifdef BUS_TIMER_PRESCALE_EN
    // PSC=3: one decrement every 4 counting cycles.
    reset = 1'b0; step(); reset = 1'b1;
    wr(ADDR_PRESET, 32'd2, 4'hF);
    wr(ADDR_CTRL, 32'h0309, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      step();
      rp = (k < 2) ? 0 : 2 - (k - 2) / 4;
      chk_rd("psc_count", ADDR_COUNT, 32'((rp < 0) ? 0 : rp));
      chk_irq("psc_irq", (k >= 10) ? 1 : 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped programmable countdown timer.
- Acts as a responder on the mini_machine I/O bus; the MIPS core is the initiator, driving word address, byte enables, write data and write strobe through the bridge.
- Raises a hardware interrupt (irq) to the CPU's HardInt input when the count expires.
- Supports one-shot and auto-reload modes.

Parameters:
- CNT_W, 32, width of the PRESET and COUNT registers (at most 32; upper bits read as 0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  2  register word select (CPU address bits [3:2]).
- we  input  1  write strobe from bridge.
- be  input  4  byte enables for writes; be[i] covers wdata[8i+7:8i].
- wdata  input  32  write data from CPU.
- rdata  output  32  read data, combinational from addr.
- irq  output  1  interrupt request, level.

Behaviour:
- Register map by addr:
  - 0 = CTRL (read/write).
  - 1 = PRESET (read/write).
  - 2 = COUNT (read-only; writes ignored).
  - 3 = reserved (reads 0, writes ignored).
- CTRL fields:
  - bit0 EN.
  - bits[2:1] MODE: 00 one-shot, 01 auto-reload, 1x behaves as one-shot.
  - bit3 IM (interrupt mask, 1 = enabled).
  - Other bits read 0.
- Writes honour be per byte. A write with be=0 changes nothing but still counts as an access.
- Reset (asynchronous, reset=0): CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state=IDLE, rdata reflects zeros, irq=0.
- irq = irq_pend & IM.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT:
    - EN=0 → IDLE; COUNT holds.
    - COUNT>1: COUNT<=COUNT-1.
    - COUNT≤1: COUNT<=0, irq_pend<=1 → INT.
  - INT:
    - MODE one-shot: hardware clears EN → IDLE; irq_pend stays set.
    - MODE auto-reload: → LOAD; irq_pend cleared on the next CNT entry, giving a 2-cycle irq pulse per period.
- Latency: with EN written at edge t and PRESET=P≥1, COUNT=P after edge t+2, and irq is visible after edge t+P+2. With P=0, irq is visible after edge t+3.
- Auto-reload period is P+2 cycles.
- Any write to PRESET while EN=1 forces the next state to LOAD (restart with the new value).
- Any write to CTRL clears irq_pend.
- Simultaneous events:
  - A CPU CTRL write and the hardware EN clear in INT on the same edge: the CPU write wins.
  - A CPU write clearing EN on the edge COUNT reaches 0: no interrupt; state → IDLE.
- COUNT never wraps below 0.
- Reset asserted mid-count returns everything to reset values immediately, with no interrupt.

Optional Feature:
- Macro: BUS_TIMER_PRESCALE_EN.
- Defined:
  - CTRL[15:8] is an R/W 8-bit PSC field.
  - In CNT, COUNT decrements only when an internal prescale counter hits PSC; the prescale counter reloads to 0 on LOAD.
  - The effective tick is every PSC+1 cycles; PSC=0 is identical to the non-prescaled behaviour.
- Undefined: CTRL[15:8] reads 0, and COUNT decrements every CNT cycle.

Decomposition:
- Shared package holds:
  - register address constants (ADDR_CTRL=0, ADDR_PRESET=1, ADDR_COUNT=2);
  - CTRL bit positions (EN, MODE lsb/msb, IM, PSC lsb/msb);
  - MODE codes;
  - FSM state encoding.
- One natural sub-module, timer_prescaler: tick generator, instantiated only under BUS_TIMER_PRESCALE_EN.
- Register file, byte-enable merge and FSM stay in bus_timer.

Test Plan:
- Reset check: hold reset=0 for 2 cycles, release → rdata=0 at addr 0/1/2/3, irq=0; reset=0 mid-count (COUNT=3) → COUNT=0, irq=0 immediately.
- One-shot: PRESET=5, CTRL=0x9 (EN, IM, mode 0) at edge t → COUNT reads 5,4,3,2,1,0 after edges t+2..t+7; irq=1 from t+7 onward; CTRL reads 0x8; writing CTRL=0 drops irq.
- Auto-reload: PRESET=3, CTRL=0xB → irq pulses with a 5-cycle period, each pulse 2 cycles wide, for at least 4 periods.
- Byte enables: PRESET=0, write 0xAABBCCDD with be=4'b0101 → PRESET reads 0x00BB00DD; write to addr 2 → COUNT unchanged.
- Mask and edge race: CTRL=0x1 (IM=0), PRESET=2 → irq stays 0 while irq_pend sets; writing CTRL=0 on the edge COUNT goes 1→0 → no irq, state IDLE.
- With BUS_TIMER_PRESCALE_EN: CTRL=0x0309 (PSC=3), PRESET=2 → COUNT decrements once every 4 cycles; irq after edge t+2+8.
